clk_strobe_gen: RTL and testbench
=================================

CLK_STROBE_GEN -- requirements
Module: clk_strobe_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 6, giving the number of strobe channels (legal 1..8).
REQ-002 The block SHALL have parameter ACC_W, default 32, giving the phase-accumulator width in bits (legal 8..32).
REQ-003 The block SHALL have parameter SETTLE_CYC, default 1024, giving the cycles of stable lock required before run (legal 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-007 The block SHALL have port cfg_we, input, 1 bit: increment-write strobe.
REQ-008 The block SHALL have port cfg_ch, input, 3 bits: channel index for the write.
REQ-009 The block SHALL have port cfg_inc, input, ACC_W bits: new phase increment.
REQ-010 The block SHALL have port cfg_clr, input, 1 bit: when set with cfg_we, also clear the addressed accumulator.
REQ-011 The block SHALL have port resync, input, 1 bit: clears all accumulators in the same cycle.
REQ-012 The block SHALL have port strobe, output, NUM_CH bits: one-cycle clock-enable pulse per channel.
REQ-013 The block SHALL have port ready, output, 1 bit: high while the block is in RUN.

Function
REQ-014 pll_locked SHALL be synchronised through a 2-flop synchroniser before use; the synchronised value is lock_s.
REQ-015 The FSM SHALL have three states: WAIT_LOCK, SETTLE and RUN.
REQ-016 FSM transitions:
- WAIT_LOCK->SETTLE when lock_s=1; the settle counter loads 0.
- SETTLE->RUN when the counter reaches SETTLE_CYC-1 with lock_s=1.
- SETTLE->WAIT_LOCK when lock_s=0.
- RUN->WAIT_LOCK when lock_s=0.
REQ-017 ready SHALL be registered and equal 1 exactly in the cycles when the state is RUN.
REQ-018 Per channel in RUN: acc <= (acc + inc) mod 2^ACC_W, and strobe <= carry-out of that ACC_W-bit add (registered, 1-cycle latency).
REQ-019 Outside RUN, all accumulators SHALL hold 0 and strobe SHALL be 0; increments are retained.
REQ-020 The mean strobe rate SHALL be f_clk*inc/2^ACC_W. inc=0 SHALL never strobe. inc=2^(ACC_W-1) SHALL strobe every second cycle.
REQ-021 A cfg_we write with cfg_ch<NUM_CH SHALL update that channel's inc, effective for the add in the following cycle. A write with cfg_ch>=NUM_CH SHALL be ignored.
REQ-022 cfg_we with cfg_clr=1 SHALL set the addressed accumulator to 0 in the same update that loads the new inc; that channel's strobe SHALL be 0 that cycle.
REQ-023 resync=1 SHALL set all accumulators to 0 and force strobe to 0 that cycle. resync takes priority over cfg_clr and over the normal add.
REQ-024 Simultaneous cfg_we and resync SHALL still load the new inc.
REQ-025 On the RUN->WAIT_LOCK transition, strobe SHALL be 0 from the next cycle, with no partial pulse.

Reset
REQ-026 While rst_n=0, all state SHALL asynchronously reset as follows:
- state=WAIT_LOCK
- synchroniser flops, settle counter and all accumulators = 0
- every inc = 0
- strobe = 0
- ready = 0
REQ-027 Reset release SHALL be synchronous to clk, handled externally; the block imposes no extra deassertion requirement.

Structure
REQ-028 A package clk_strobe_pkg SHALL hold the FSM state enum (WAIT_LOCK, SETTLE, RUN), the NUM_CH/ACC_W/SETTLE_CYC defaults and the channel-index width constant.
REQ-029 One sub-module strobe_nco (accumulator, increment register, clear and carry logic, parameter ACC_W) SHALL be instantiated NUM_CH times by a generate loop.
REQ-030 The FSM, synchroniser, settle counter and config decode SHALL reside in clk_strobe_gen.

Verification
REQ-031 Lock/settle test: SETTLE_CYC=16; assert pll_locked.
- Required: ready rises exactly 2+16+1 cycles after lock_s sampling (19 clk edges, ±1 for synchroniser phase).
- Required: strobe stays 0 before ready.
REQ-032 Rate test: ACC_W=32; ch0 inc=0x80000000, ch1 inc=0x99999999 (0.6).
- Required: ch0 pulses every 2 cycles.
- Required: ch1 gives exactly 600 pulses in 1000 RUN cycles (±1).
REQ-033 Lock loss test: drop pll_locked mid-RUN.
- Required: ready and all strobes are 0 within 3 cycles.
- Required: accumulators read 0.
- Required: relock repeats the full SETTLE.
REQ-034 Resync test: ch0 inc=0x40000000, ch1 inc=0x20000000; pulse resync, colliding with a cfg_we to ch2.
- Required: ch0's first strobe is 4 cycles after resync and ch1's first is 8 cycles after.
- Required: ch2's new inc is applied.
REQ-035 Config edge test:
- cfg_ch=7 with NUM_CH=6 -> no state change.
- inc=0 -> no strobes over 10000 cycles.
- cfg_clr write -> that channel's phase restarts with no pulse in the write cycle.
REQ-036 Reset test: assert rst_n=0 mid-RUN with strobes active.
- Required: outputs go to 0 without a clock edge.
- Required: after release, all inc=0 and state=WAIT_LOCK.

Source files
------------

// File: rtl/clk_strobe_pkg.sv
// clk_strobe_pkg: shared FSM state type and default sizing for the strobe generator.
package clk_strobe_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;
    localparam int NUM_CH_DEF     = 6;
    localparam int ACC_W_DEF      = 32;
    localparam int SETTLE_CYC_DEF = 1024;
    localparam int CH_W           = 3;
    localparam int CNT_W          = 16;
endpackage

// File: rtl/strobe_nco.sv
// strobe_nco: one phase-accumulator channel; the add carry-out is the strobe.
module strobe_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             strobe_o
);
    logic [ACC_W-1:0] acc_q, inc_q;
    logic             strobe_q;
    logic [ACC_W:0]   sum;

    assign sum      = {1'b0, acc_q} + {1'b0, inc_q};
    assign strobe_o = strobe_q;

    // The add uses the old increment, so a write takes effect on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            inc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            if (we_i) inc_q <= inc_i;
            if (!run_i || clr_i) begin
                acc_q    <= '0;
                strobe_q <= 1'b0;
            end else begin
                {strobe_q, acc_q} <= sum;
            end
        end
    end
endmodule

// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: lock-qualified multi-channel NCO clock-enable generator.
module clk_strobe_gen
    import clk_strobe_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_clr,
    input  logic              resync,
    output logic [NUM_CH-1:0] strobe,
    output logic              ready
);
    logic [1:0]       sync_q;
    logic             lock_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             run_d;

    assign lock_s = sync_q[1];
    assign state_d = !lock_s ? WAIT_LOCK :
                     (state_q == WAIT_LOCK) ? SETTLE :
                     (state_q == SETTLE && cnt_q == CNT_W'(SETTLE_CYC - 1)) ? RUN : state_q;
    // Channels follow the next state so strobes line up with ready and never leak past lock loss.
    assign run_d = (state_d == RUN);
    assign ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pll_locked};
            state_q <= state_d;
            cnt_q   <= (state_q == SETTLE) ? cnt_q + 1'b1 : '0;
            ready_q <= run_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = cfg_we && (cfg_ch == CH_W'(i));
        strobe_nco #(.ACC_W(ACC_W)) u_nco (
            .clk      (clk),
            .rst_n    (rst_n),
            .run_i    (run_d),
            .clr_i    (resync || (sel && cfg_clr)),
            .we_i     (sel),
            .inc_i    (cfg_inc),
            .strobe_o (strobe[i])
        );
    end
endmodule

// File: tb/tb_clk_strobe_gen.sv
// tb_clk_strobe_gen: randomized and directed checks against a phase/lock-count reference model.
module tb_clk_strobe_gen;
    localparam int NUM_CH     = 6;
    localparam int ACC_W      = 32;
    localparam int SETTLE_CYC = 16;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pll_locked = 1'b0;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic              cfg_clr = 1'b0;
    logic              resync = 1'b0;
    logic [NUM_CH-1:0] strobe;
    logic              ready;

    always #5 clk = ~clk;

    clk_strobe_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_clr    (cfg_clr),
        .resync     (resync),
        .strobe     (strobe),
        .ready      (ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: phase as plain integers, lock as a count of consecutive locked samples.
    longint unsigned   m_phase [NUM_CH];
    longint unsigned   m_inc [NUM_CH];
    bit                h0, h1;
    int                lock_run;
    logic [NUM_CH-1:0] m_strobe;
    bit                m_ready;
    int                pulses [NUM_CH];

    function automatic void model_reset();
        h0 = 0; h1 = 0; lock_run = 0; m_strobe = '0; m_ready = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = 0;
            m_inc[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit lock_pre;
        longint unsigned s;
        lock_pre = h1;
        h1 = h0;
        h0 = pll_locked;
        lock_run = lock_pre ? ((lock_run < 1000000) ? lock_run + 1 : lock_run) : 0;
        m_ready = (lock_run >= SETTLE_CYC + 1);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!m_ready || resync || (cfg_we && cfg_clr && int'(cfg_ch) == c)) begin
                m_phase[c] = 0;
                m_strobe[c] = 1'b0;
            end else begin
                s = m_phase[c] + m_inc[c];
                m_strobe[c] = (s >= MOD);
                m_phase[c] = s % MOD;
            end
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) m_inc[cfg_ch] = 64'(cfg_inc);
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        @(negedge clk);
        chk("strobe", 32'(strobe), 32'(m_strobe));
        chk("ready", 32'(ready), 32'(m_ready));
        for (int c = 0; c < NUM_CH; c++) pulses[c] += int'(strobe[c]);
    endtask

    task automatic cfg(input int ch, input logic [31:0] inc, input bit clr);
        cfg_we = 1'b1; cfg_ch = ch[2:0]; cfg_inc = inc; cfg_clr = clr;
        step();
        cfg_we = 1'b0; cfg_clr = 1'b0;
    endtask

    task automatic clear_pulses();
        for (int c = 0; c < NUM_CH; c++) pulses[c] = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
    endtask

    int n, first0, first1, first2, alt_err, total;
    logic [NUM_CH-1:0] pre;
    logic prev0;

    initial begin
        model_reset();
        clear_pulses();
        repeat (3) step();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_strobe", 32'(strobe), 0);
        rst_n = 1'b1;
        step();

        cfg(0, 32'h8000_0000, 0);
        cfg(1, 32'h9999_9999, 0);
        pll_locked = 1'b1;
        pre = '0; n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
            if (!ready) pre |= strobe;
        end
        chk("lock_lat", 32'(n), 19);
        chk("pre_ready_strobe", 32'(pre), 0);

        clear_pulses();
        alt_err = 0; prev0 = 1'b0;
        repeat (1000) begin
            step();
            if (strobe[0] == prev0) alt_err++;
            prev0 = strobe[0];
        end
        chk("ch0_rate", 32'(pulses[0]), 500);
        chk("ch0_alt", 32'(alt_err), 0);
        chk("ch1_rate", 32'(pulses[1] >= 599 && pulses[1] <= 601), 1);

        cfg(0, 32'h4000_0000, 0);
        cfg(1, 32'h2000_0000, 0);
        resync = 1'b1;
        cfg(2, 32'h1000_0000, 0);
        resync = 1'b0;
        first0 = -1; first1 = -1; first2 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (strobe[0] && first0 < 0) first0 = k;
            if (strobe[1] && first1 < 0) first1 = k;
            if (strobe[2] && first2 < 0) first2 = k;
        end
        chk("resync_ch0", 32'(first0), 4);
        chk("resync_ch1", 32'(first1), 8);
        chk("resync_ch2_inc", 32'(first2), 16);

        pll_locked = 1'b0;
        n = 0;
        while ((ready || strobe != '0) && n < 10) begin
            step();
            n++;
        end
        chk("loss_lat", 32'(n), 3);
        repeat (5) step();
        pll_locked = 1'b1;
        wait_ready(n);
        chk("relock_lat", 32'(n), 19);
        first0 = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (strobe[0] && first0 < 0) first0 = k;
        end
        chk("relock_phase", 32'(first0), 3);

        repeat (400) begin
            cfg_we = ($urandom % 4) == 0;
            cfg_ch = 3'($urandom % 8);
            cfg_inc = $urandom;
            cfg_clr = ($urandom % 3) == 0;
            resync = ($urandom % 16) == 0;
            pll_locked = ($urandom % 100) != 0;
            step();
        end
        cfg_we = 1'b0; cfg_clr = 1'b0; resync = 1'b0; pll_locked = 1'b1;
        repeat (3) step();
        wait_ready(n);
        chk("rand_relock", 32'(ready), 1);

        cfg(3, 32'h8000_0000, 0);
        cfg(7, 32'h0000_0000, 1);
        clear_pulses();
        repeat (10) step();
        chk("ch7_ignored", 32'(pulses[3]), 5);

        cfg(3, 32'h0, 0);
        step();
        clear_pulses();
        repeat (10000) step();
        chk("inc0_none", 32'(pulses[3]), 0);

        cfg(4, 32'h8000_0000, 0);
        repeat (3) step();
        cfg(4, 32'h8000_0000, 1);
        chk("clr_cycle", 32'(strobe[4]), 0);
        step();
        chk("clr_p1", 32'(strobe[4]), 0);
        step();
        chk("clr_p2", 32'(strobe[4]), 1);

        cfg(0, 32'h8000_0000, 0);
        n = 0;
        while (!strobe[0] && n < 10) begin
            step();
            n++;
        end
        chk("rst_pre_active", 32'(strobe[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_strobe", 32'(strobe), 0);
        chk("async_ready", 32'(ready), 0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        wait_ready(n);
        chk("post_rst_lat", 32'(n), 19);
        clear_pulses();
        repeat (100) step();
        total = 0;
        for (int c = 0; c < NUM_CH; c++) total += pulses[c];
        chk("post_rst_inc0", 32'(total), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
